gayle_irq_regs: RTL and testbench
=================================

// Module: gayle_irq_regs
// PURPOSE
//  Gayle-compatible IDE interrupt and ID register block. It sits beside the IDE
//  PIO decoder ($DA0000-$DA7FFF) and serves the registers that consume the
//  drive INTRQ line: status $DA8xxx, INTREQ $DA9xxx, INTENA $DAAxxx and the
//  Gayle ID $DE1xxx. It drives D[31:24] and DTACK for these cycles and raises
//  INT2 toward the CPU.
// PARAMETERS
//  GAYLE_ID   8'hD0  ID byte, returned one bit per read on DOUT[7], MSB first
//  ACK_DLY    2      CLK posedges after synced AS-low before DTACK asserts (>=1)
// PORTS
//  CLK     in   1   bus clock; all state changes on posedge
//  RESET   in   1   asynchronous, active-high reset
//  AS      in   1   68k address strobe, active-low, asynchronous to CLK
//  RW      in   1   1 = read, 0 = write
//  A       in   24  address bus
//  DIN     in   8   write data, D[31:24]
//  INTRQ   in   1   IDE drive interrupt, active-high, asynchronous
//  DOUT    out  8   read data for D[31:24]
//  DOE     out  1   1 = drive DOUT onto D[31:24]
//  DTACK   out  1   active-low data acknowledge
//  INT2    out  1   active-low interrupt request to the CPU
//  ACCESS  out  1   active-low combinational register-window hit (not gated by AS)
// BEHAVIOUR
//  Reset values: DOUT=0, DOE=0, DTACK=1, INT2=1, INTREQ=0, INTENA=0, id_cnt=0,
//   FSM=IDLE, INTRQ sync flops=0.
//  Decode: hit = (A[23:12] in {DA8,DA9,DAA}) | (A[23:12]==DE1). ACCESS = ~hit.
//  AS is synchronised with 2 flops (as_s). The FSM samples only the synced value.
//  FSM:
//   IDLE : as_s==0 & hit -> WAIT, cnt=0. as_s==0 & ~hit -> stays in IDLE.
//   WAIT : cnt++. At cnt==ACK_DLY-1 -> ACK. as_s==1 -> IDLE (aborted cycle).
//   ACK  : one cycle. DTACK_INT=0. DOUT is latched on the entry edge.
//          A write commits on this edge. An ID read advances id_cnt on this
//          edge. Always -> HOLD.
//   HOLD : DTACK_INT stays 0 until as_s==1, then -> IDLE and DTACK_INT=1.
//  DTACK = DTACK_INT | AS. DTACK releases combinationally when AS rises.
//  DOE   = RW & ~AS & (state in WAIT, ACK, HOLD). DOE is 0 for writes.
//  Read data; unused bits read 0:
//   DA8 status : DOUT[7] = irq_s, the synced INTRQ level
//   DA9 INTREQ : DOUT[7] = INTREQ[7]
//   DAA INTENA : DOUT    = INTENA[7:0]
//   DE1 ID     : DOUT[7] = GAYLE_ID[7-id_cnt]
//  Writes:
//   DA8 : ignored
//   DA9 : INTREQ[7] <= INTREQ[7] & DIN[7] (write 0 to clear)
//   DAA : INTENA <= DIN
//   DE1 : id_cnt <= 0
//  id_cnt is 3 bits. It wraps 7->0 after 8 reads.
//  INTRQ: 2-flop sync to irq_s, then a third flop for edge detect. A rising
//   edge of irq_s sets INTREQ[7]. Falling edges have no effect.
//  If an INTRQ rising edge and a DA9 clear-write fall on the same edge, the set
//   wins and INTREQ[7]=1.
//  INT2 is registered: INT2 <= ~(INTREQ[7] & INTENA[7]). It reflects changes
//   1 CLK after the register update.
//  RESET mid-cycle forces all reset values immediately; DTACK=1 and DOE=0 at
//   once. If AS is still low when RESET deasserts, the FSM waits in IDLE for as_s
//   to be seen high, then low, before it starts a new cycle. It does not ack the
//   stale cycle.
//  There is no timeout. A stuck AS leaves the FSM in HOLD until AS rises or
//   RESET asserts.
// TESTING
//  T1 Reset, then read $DE1000 eight times -> DOUT[7] = 1,1,0,1,0,0,0,0; the
//     ninth read = 1 (wrap). Write $DE1000, then read -> 1 (counter cleared).
//  T2 Read $DAA000 with ACK_DLY=2, AS low at t0 -> DTACK falls on the 4th posedge
//     after AS falls (2 sync + 2 WAIT). It releases combinationally when AS rises.
//  T3 INTENA=8'h80; pulse INTRQ high -> INTREQ[7]=1 and INT2=0. Read $DA8000
//     -> DOUT=8'h80 while INTRQ is high. Write $DA9000 with 8'h00 -> INT2=1 one
//     CLK later.
//  T4 Align an INTRQ rising edge (post-sync) with the DA9 clear-write commit
//     edge -> INTREQ[7] stays 1 and INT2 stays 0.
//  T5 Access $DA0000 (IDE window) and $DAC000 -> ACCESS=1, DTACK=1, DOE=0 for
//     the whole cycle.
//  T6 Assert RESET during HOLD of an INTENA write -> DTACK=1 and INTENA=0 at
//     once. After RESET drops with AS still low -> no DTACK until a fresh AS cycle.

Source files
------------

// File: rtl/gayle_irq_regs.sv
// Gayle-compatible IDE interrupt, interrupt-enable and ID register block.
// Serves $DA8/$DA9/$DAA/$DE1 cycles with DTACK and drives INT2 toward the CPU.
module gayle_irq_regs #(
  parameter logic [7:0] GAYLE_ID = 8'hD0,
  parameter int         ACK_DLY  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AS,
  input  logic        RW,
  input  logic [23:0] A,
  input  logic [7:0]  DIN,
  input  logic        INTRQ,
  output logic [7:0]  DOUT,
  output logic        DOE,
  output logic        DTACK,
  output logic        INT2,
  output logic        ACCESS
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    HOLD
  } state_t;

  localparam logic [7:0] CNT_LAST =
    (ACK_DLY > 1) ? 8'(ACK_DLY - 2) : 8'd0;
  localparam bit FAST_ACK = (ACK_DLY <= 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        dtack_q;
  logic        as_m_q, as_s_q;
  logic        armed_q;
  logic        irq_m_q, irq_s_q, irq_d_q;
  logic        intreq_q, intreq_d;
  logic [7:0]  intena_q, intena_d;
  logic [2:0]  id_q, id_d;
  logic [7:0]  dout_q, dout_d;
  logic        int2_q;

  logic [11:0] page;
  logic        sel_st, sel_rq, sel_en, sel_id, hit;
  logic        start, go_ack, wr, rd, irq_rise;
  logic [7:0]  rd_data;
  logic        unused_a;

  assign page   = A[23:12];
  assign sel_st = (page == 12'hDA8);
  assign sel_rq = (page == 12'hDA9);
  assign sel_en = (page == 12'hDAA);
  assign sel_id = (page == 12'hDE1);
  assign hit    = sel_st | sel_rq | sel_en | sel_id;
  assign unused_a = ^A[11:0];

  // armed_q blocks a cycle left over from reset until AS is seen high
  assign start    = armed_q & ~as_s_q & hit;
  assign irq_rise = irq_s_q & ~irq_d_q;

  always_comb begin
    go_ack = 1'b0;
    unique case (state_q)
      IDLE:    go_ack = FAST_ACK & start;
      WAIT:    go_ack = ~as_s_q & (cnt_q == CNT_LAST);
      default: go_ack = 1'b0;
    endcase
  end

  assign wr = go_ack & ~RW;
  assign rd = go_ack & RW;

  always_comb begin
    rd_data = 8'h00;
    unique case (1'b1)
      sel_st:  rd_data = {irq_s_q, 7'b0};
      sel_rq:  rd_data = {intreq_q, 7'b0};
      sel_en:  rd_data = intena_q;
      sel_id:  rd_data = {GAYLE_ID[3'd7 - id_q], 7'b0};
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    intreq_d = intreq_q;
    intena_d = intena_q;
    id_d     = id_q;
    dout_d   = dout_q;
    if (wr && sel_rq) intreq_d = intreq_q & DIN[7];
    // a rising INTRQ beats a simultaneous clear
    if (irq_rise) intreq_d = 1'b1;
    if (wr && sel_en) intena_d = DIN;
    if (wr && sel_id) id_d = 3'd0;
    if (rd && sel_id) id_d = id_q + 3'd1;
    if (go_ack) dout_d = rd_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      as_m_q   <= 1'b0;
      as_s_q   <= 1'b0;
      armed_q  <= 1'b0;
      irq_m_q  <= 1'b0;
      irq_s_q  <= 1'b0;
      irq_d_q  <= 1'b0;
      intreq_q <= 1'b0;
      intena_q <= 8'h00;
      id_q     <= 3'd0;
      dout_q   <= 8'h00;
      int2_q   <= 1'b1;
    end else begin
      as_m_q   <= AS;
      as_s_q   <= as_m_q;
      armed_q  <= armed_q | as_s_q;
      irq_m_q  <= INTRQ;
      irq_s_q  <= irq_m_q;
      irq_d_q  <= irq_s_q;
      intreq_q <= intreq_d;
      intena_q <= intena_d;
      id_q     <= id_d;
      dout_q   <= dout_d;
      int2_q   <= ~(intreq_q & intena_q[7]);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      dtack_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= 8'd0;
            state_q <= go_ack ? ACK : WAIT;
            if (go_ack) dtack_q <= 1'b0;
          end
        end
        WAIT: begin
          if (as_s_q) begin
            state_q <= IDLE;
          end else if (go_ack) begin
            state_q <= ACK;
            dtack_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ACK: state_q <= HOLD;
        HOLD: begin
          if (as_s_q) begin
            state_q <= IDLE;
            dtack_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DOUT   = dout_q;
  assign DTACK  = dtack_q | AS;
  assign DOE    = RW & ~AS & (state_q != IDLE);
  assign INT2   = int2_q;
  assign ACCESS = ~hit;

endmodule

// File: tb/tb_gayle_irq_regs.sv
// Directed and randomized bench for gayle_irq_regs against a register-level
// model of the interrupt, enable and ID registers.
module tb_gayle_irq_regs;

  localparam logic [7:0] ID = 8'hD0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        AS;
  logic        RW;
  logic [23:0] A;
  logic [7:0]  DIN;
  logic        INTRQ;
  logic [7:0]  DOUT;
  logic        DOE;
  logic        DTACK;
  logic        INT2;
  logic        ACCESS;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_intena;
  logic       m_intreq;
  logic [2:0] m_id;
  logic       m_irq;

  gayle_irq_regs #(
    .GAYLE_ID(ID),
    .ACK_DLY (2)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .AS    (AS),
    .RW    (RW),
    .A     (A),
    .DIN   (DIN),
    .INTRQ (INTRQ),
    .DOUT  (DOUT),
    .DOE   (DOE),
    .DTACK (DTACK),
    .INT2  (INT2),
    .ACCESS(ACCESS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_int2();
    return {7'b0, ~(m_intreq & m_intena[7])};
  endfunction

  task automatic model_acc(input logic [23:0] addr, input logic rw,
                           input logic [7:0] din, output logic [7:0] exp);
    logic [7:0] id;
    id  = ID;
    exp = 8'h00;
    case (addr[23:12])
      12'hDA8: if (rw) exp = {m_irq, 7'b0};
      12'hDA9: begin
        if (rw) exp = {m_intreq, 7'b0};
        else m_intreq = m_intreq & din[7];
      end
      12'hDAA: begin
        if (rw) exp = m_intena;
        else m_intena = din;
      end
      12'hDE1: begin
        if (rw) begin
          exp  = {id[3'd7 - m_id], 7'b0};
          m_id = m_id + 3'd1;
        end else begin
          m_id = 3'd0;
        end
      end
      default: exp = 8'h00;
    endcase
  endtask

  task automatic bus(input logic [23:0] addr, input logic rw,
                     input logic [7:0] din, input int irq_at,
                     output logic [7:0] dout, output logic i2a,
                     output logic i2n);
    int lat;
    lat  = 0;
    dout = 8'h00;
    i2a  = 1'b1;
    i2n  = 1'b1;
    @(negedge CLK);
    A   = addr;
    RW  = rw;
    DIN = din;
    AS  = 1'b0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(posedge CLK);
      #1;
      if (irq_at == n) INTRQ = 1'b1;
      if (DTACK == 1'b0) lat = n;
    end
    chk("ack_latency", 8'(lat), 8'd4);
    if (lat != 0) begin
      dout = DOUT;
      i2a  = INT2;
      chk("doe_at_ack", {7'b0, DOE}, {7'b0, rw});
      chk("access_hit", {7'b0, ACCESS}, 8'd0);
      @(posedge CLK);
      #1;
      i2n = INT2;
    end
    @(negedge CLK);
    AS = 1'b1;
    #1;
    chk("dtack_release", {7'b0, DTACK}, 8'd1);
    chk("doe_release", {7'b0, DOE}, 8'd0);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic op(input logic [23:0] addr, input logic rw,
                    input logic [7:0] din);
    logic [7:0] exp, d;
    logic       a, b;
    model_acc(addr, rw, din, exp);
    bus(addr, rw, din, 0, d, a, b);
    if (rw) chk($sformatf("read_%h", addr[23:12]), d, exp);
    chk("int2_after_op", {7'b0, INT2}, exp_int2());
  endtask

  task automatic set_irq(input logic v);
    @(negedge CLK);
    if (v && !m_irq) m_intreq = 1'b1;
    m_irq = v;
    INTRQ = v;
    repeat (5) @(posedge CLK);
    #1;
    chk("int2_after_irq", {7'b0, INT2}, exp_int2());
  endtask

  task automatic nohit(input logic [23:0] addr);
    @(negedge CLK);
    A   = addr;
    RW  = 1'($urandom);
    DIN = 8'($urandom);
    AS  = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("nohit_%h", addr[23:12]),
          {5'b0, ACCESS, DTACK, DOE}, 8'b0000_0110);
    end
    @(negedge CLK);
    AS = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0]  e, d;
    logic        a, b, got;
    logic [11:0] pg;
    logic [11:0] pages [4];
    int          k;
    pages[0] = 12'hDA8;
    pages[1] = 12'hDA9;
    pages[2] = 12'hDAA;
    pages[3] = 12'hDE1;
    m_intena = 8'h00;
    m_intreq = 1'b0;
    m_id     = 3'd0;
    m_irq    = 1'b0;
    RESET = 1'b1;
    AS    = 1'b1;
    RW    = 1'b1;
    A     = 24'h0;
    DIN   = 8'h00;
    INTRQ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_dtack", {7'b0, DTACK}, 8'd1);
    chk("rst_int2", {7'b0, INT2}, 8'd1);
    chk("rst_doe", {7'b0, DOE}, 8'd0);
    chk("rst_dout", DOUT, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    // ID shift-out: 1,1,0,1,0,0,0,0 then wrap, then clear by write
    for (int i = 0; i < 9; i++) op(24'hDE1000, 1'b1, 8'h00);
    op(24'hDE1000, 1'b0, 8'h5A);
    op(24'hDE1000, 1'b1, 8'h00);

    // enable, interrupt, status read and clear
    op(24'hDAA000, 1'b0, 8'h80);
    op(24'hDAA000, 1'b1, 8'h00);
    set_irq(1'b1);
    op(24'hDA8000, 1'b1, 8'h00);
    op(24'hDA9000, 1'b1, 8'h00);
    set_irq(1'b0);
    model_acc(24'hDA9000, 1'b0, 8'h00, e);
    bus(24'hDA9000, 1'b0, 8'h00, 0, d, a, b);
    chk("clr_int2_at_commit", {7'b0, a}, 8'd0);
    chk("clr_int2_next_clk", {7'b0, b}, 8'd1);

    // rising INTRQ on the clear-write commit edge
    set_irq(1'b1);
    set_irq(1'b0);
    model_acc(24'hDA9000, 1'b0, 8'h00, e);
    m_intreq = 1'b1;
    m_irq    = 1'b1;
    bus(24'hDA9000, 1'b0, 8'h00, 1, d, a, b);
    chk("race_int2_commit", {7'b0, a}, 8'd0);
    chk("race_int2_next", {7'b0, b}, 8'd0);
    op(24'hDA9000, 1'b1, 8'h00);
    set_irq(1'b0);

    nohit(24'hDA0000);
    nohit(24'hDAC000);

    for (int it = 0; it < 60; it++) begin
      k = $urandom_range(0, 9);
      if (k <= 6) begin
        op({pages[k % 4], 12'($urandom)}, 1'($urandom), 8'($urandom));
      end else if (k <= 8) begin
        set_irq(~m_irq);
      end else begin
        pg = 12'($urandom);
        if (pg inside {12'hDA8, 12'hDA9, 12'hDAA, 12'hDE1}) pg = 12'hDAC;
        nohit({pg, 12'($urandom)});
      end
    end

    // reset during HOLD of an enable write, AS left low across reset
    set_irq(1'b0);
    op(24'hDA9000, 1'b0, 8'h00);
    set_irq(1'b1);
    set_irq(1'b0);
    @(negedge CLK);
    A   = 24'hDAA000;
    RW  = 1'b0;
    DIN = 8'h80;
    AS  = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      @(posedge CLK);
      #1;
      if (DTACK == 1'b0) got = 1'b1;
    end
    chk("t6_ack", {7'b0, got}, 8'd1);
    m_intena = 8'h80;
    repeat (3) @(posedge CLK);
    #1;
    chk("t6_hold_dtack", {7'b0, DTACK}, 8'd0);
    chk("t6_hold_int2", {7'b0, INT2}, 8'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("t6_rst_dtack", {7'b0, DTACK}, 8'd1);
    chk("t6_rst_doe", {7'b0, DOE}, 8'd0);
    chk("t6_rst_int2", {7'b0, INT2}, 8'd1);
    chk("t6_rst_dout", DOUT, 8'h00);
    m_intena = 8'h00;
    m_intreq = 1'b0;
    m_id     = 3'd0;
    @(negedge CLK);
    RESET = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge CLK);
      #1;
      chk("t6_stale_dtack", {7'b0, DTACK}, 8'd1);
    end
    @(negedge CLK);
    AS = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    op(24'hDAA000, 1'b1, 8'h00);
    op(24'hDA9000, 1'b1, 8'h00);
    op(24'hDE1000, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
